// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store initiator for a word memory.
// Accepts one request in IDLE, strobes the memory for one cycle, waits out the
// memory read latency, then holds a response until the consumer takes it.
// Out-of-range addresses go straight to an error response without a strobe.
// MEM_DEPTH is expected to be <= 2**ADDR_W; equality disables the range error.
module mem_access_unit #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_DEPTH  = 1024,
    parameter int RD_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    // One extra bit so MEM_DEPTH == 2**ADDR_W is representable and never trips.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              in_range;

    assign in_range = {1'b0, req_addr} < DEPTH_L;

    // Next-state and datapath update; strobes are registered so they appear
    // only during the ISSUE cycle.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        write_d     = write_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    rdata_d = '0;
                    err_d   = ~in_range;
                    if (in_range) begin
                        state_d     = ISSUE;
                        mem_write_d = req_write;
                        mem_read_d  = ~req_write;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(RD_LATENCY);
                state_d = write_q ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Last wait cycle: memory data is valid now, earlier values are stale.
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            write_q     <= write_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // req_ready is masked while reset is held so every output reads 0 in reset.
    assign req_ready  = (state_q == IDLE) & ~reset;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (read latency 1 and 3), each with a
// behavioural registered-read memory. Stimulus pushes expected strobes and
// responses into per-instance queues; monitors pop and compare.
module tb_mem_access_unit;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 1024;
    localparam int NI    = 2;

    typedef struct {
        int          cyc;
        logic [DW-1:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } strb_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;

    logic          rst        [NI];
    logic          req_valid  [NI];
    logic          req_ready  [NI];
    logic          req_write  [NI];
    logic [AW-1:0] req_addr   [NI];
    logic [DW-1:0] req_wdata  [NI];
    logic          resp_valid [NI];
    logic          resp_ready [NI];
    logic [DW-1:0] resp_rdata [NI];
    logic          resp_err   [NI];
    logic          mem_read   [NI];
    logic          mem_write  [NI];
    logic [AW-1:0] mem_addr   [NI];
    logic [DW-1:0] mem_wdata  [NI];
    logic [DW-1:0] mem_rdata  [NI];

    resp_t         exp_r [NI][$];
    strb_t         exp_s [NI][$];
    logic [DW-1:0] ref_mem [NI][DEPTH];
    int            hold_until [NI];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : inst
        localparam int LAT = (g == 0) ? 1 : 3;

        mem_access_unit #(
            .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .RD_LATENCY(LAT)
        ) dut (
            .CLK(CLK), .reset(rst[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_write(req_write[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g]),
            .mem_read(mem_read[g]), .mem_write(mem_write[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );

        // Behavioural memory: registered read, LAT cycles; junk shifts in when idle.
        logic [DW-1:0] mem  [DEPTH];
        logic [DW-1:0] pipe [LAT];
        initial for (int k = 0; k < DEPTH; k++) mem[k] = DW'(k * 37 + 11);
        always @(posedge CLK) begin
            if (mem_write[g]) mem[mem_addr[g][9:0]] <= mem_wdata[g];
            pipe[0] <= mem_read[g] ? mem[mem_addr[g][9:0]] : DW'($urandom);
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[g] = pipe[LAT-1];

        // Response consumer: random backpressure, forced low while held.
        always @(negedge CLK)
            resp_ready[g] = (cyc < hold_until[g]) ? 1'b0 : ($urandom_range(0, 3) != 0);

        // Monitor: strobes and responses against the queued expectations.
        logic seen = 1'b0;
        always @(negedge CLK) begin
            #1;
            if (rst[g]) begin
                seen = 1'b0;
            end else begin
                if (mem_read[g] || mem_write[g]) begin
                    if (exp_s[g].size() == 0) begin
                        chk("unexpected_strobe", {mem_read[g], mem_write[g]}, 0);
                    end else begin
                        strb_t s;
                        s = exp_s[g].pop_front();
                        chk("strobe_cycle", cyc, s.cyc);
                        chk("strobe_kind", {mem_read[g], mem_write[g]}, {~s.wr, s.wr});
                        chk("strobe_addr", mem_addr[g], s.addr);
                        chk("strobe_wdata", mem_wdata[g], s.data);
                    end
                end
                if (resp_valid[g]) begin
                    chk("req_ready_in_resp", req_ready[g], 0);
                    if (exp_r[g].size() == 0) begin
                        chk("unexpected_resp", resp_valid[g], 0);
                    end else begin
                        if (!seen) chk("resp_cycle", cyc, exp_r[g][0].cyc);
                        chk("resp_rdata", resp_rdata[g], exp_r[g][0].rdata);
                        chk("resp_err", resp_err[g], exp_r[g][0].err);
                        seen = 1'b1;
                        if (resp_ready[g]) begin
                            void'(exp_r[g].pop_front());
                            seen = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Issue one request, hold it until accepted, queue what the memory and
    // response port must show.
    task automatic do_req(input int i, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        int t, n, lat;
        lat = (i == 0) ? 1 : 3;
        @(negedge CLK);
        req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i] = a; req_wdata[i] = d;
        t = 0;
        while (!req_ready[i] && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (!req_ready[i]) begin
            chk("req_accept_timeout", t, 0);
            req_valid[i] = 1'b0;
            return;
        end
        n = cyc + 1;
        if (int'(a) >= DEPTH) begin
            exp_r[i].push_back('{n, '0, 1'b1});
        end else if (wr) begin
            exp_s[i].push_back('{n, 1'b1, a, d});
            ref_mem[i][a[9:0]] = d;
            exp_r[i].push_back('{n + 1, '0, 1'b0});
        end else begin
            exp_s[i].push_back('{n, 1'b0, a, d});
            exp_r[i].push_back('{n + 1 + lat, ref_mem[i][a[9:0]], 1'b0});
        end
        @(negedge CLK);
        req_valid[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int t;
        t = 0;
        while ((exp_r[i].size() != 0 || exp_s[i].size() != 0) && t < 500) begin
            @(negedge CLK);
            t++;
        end
        chk("drain_resp_q", exp_r[i].size(), 0);
        chk("drain_strb_q", exp_s[i].size(), 0);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; req_write[i] = 1'b0;
            req_addr[i] = '0; req_wdata[i] = '0; hold_until[i] = 0;
            for (int k = 0; k < DEPTH; k++) ref_mem[i][k] = DW'(k * 37 + 11);
        end
        repeat (3) @(negedge CLK);
        #2;
        for (int i = 0; i < NI; i++) begin
            chk("rst_req_ready", req_ready[i], 0);
            chk("rst_resp_valid", resp_valid[i], 0);
            chk("rst_strobes", {mem_read[i], mem_write[i]}, 0);
            chk("rst_mem_addr", mem_addr[i], 0);
        end
        @(negedge CLK);
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        #2;
        for (int i = 0; i < NI; i++) chk("post_rst_req_ready", req_ready[i], 1);

        // Store, load back, out-of-range load.
        do_req(0, 1'b1, 16'h0005, 16'hBEEF);
        drain(0);
        do_req(0, 1'b0, 16'h0005, 16'h0000);
        drain(0);
        do_req(0, 1'b0, 16'h0400, 16'h1234);
        drain(0);

        // Response held off for several cycles while req_valid toggles.
        do_req(0, 1'b1, 16'h0007, 16'h5A5A);
        hold_until[0] = cyc + 9;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            req_valid[0] = k[0]; req_write[0] = 1'b0; req_addr[0] = 16'h0007;
            #2;
            chk("hold_req_ready", req_ready[0], 0);
        end
        req_valid[0] = 1'b0;
        do_req(0, 1'b0, 16'h0007, 16'h0000);
        drain(0);

        // Reset while waiting for load data: everything drops, nothing returns.
        do_req(0, 1'b0, 16'h0005, 16'h0000);
        @(negedge CLK);
        rst[0] = 1'b1;
        exp_r[0].delete();
        exp_s[0].delete();
        #2;
        chk("midrst_req_ready", req_ready[0], 0);
        chk("midrst_resp_valid", resp_valid[0], 0);
        chk("midrst_resp_rdata", resp_rdata[0], 0);
        chk("midrst_resp_err", resp_err[0], 0);
        chk("midrst_strobes", {mem_read[0], mem_write[0]}, 0);
        chk("midrst_mem_addr", mem_addr[0], 0);
        chk("midrst_mem_wdata", mem_wdata[0], 0);
        @(negedge CLK);
        rst[0] = 1'b0;
        #2;
        chk("midrst_release_ready", req_ready[0], 1);
        do_req(0, 1'b0, 16'h0005, 16'h0000);
        drain(0);

        // Read latency 3 instance.
        do_req(1, 1'b1, 16'h0005, 16'hBEEF);
        drain(1);
        do_req(1, 1'b0, 16'h0005, 16'h0000);
        drain(1);

        // Random traffic on both instances, including range edges.
        for (int n = 0; n < 80; n++) begin
            int i, r;
            logic [AW-1:0] a;
            i = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = AW'($urandom_range(0, 15));
            else if (r == 7) a = 16'h03FF;
            else if (r == 8) a = 16'h0400;
            else             a = AW'($urandom);
            do_req(i, 1'($urandom_range(0, 1)), a, DW'($urandom));
            if ($urandom_range(0, 3) == 0) drain(i);
        end
        drain(0);
        drain(1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
